// File: rtl/axi4_sim_sram.sv
// AXI4 full-slave SRAM model for simulation top levels.
// FIXED/INCR/WRAP bursts, fixed read latency, ID echo, DECERR/SLVERR responses.
module axi4_sim_sram #(
   parameter int DW     = 128,
   parameter int AW     = 14,
   parameter int IW     = 4,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [IW-1:0]     MEM_AWID,
   input  logic [ADDR_W-1:0] MEM_AWADDR,
   input  logic [7:0]        MEM_AWLEN,
   input  logic [2:0]        MEM_AWSIZE,
   input  logic [1:0]        MEM_AWBURST,
   input  logic              MEM_AWVALID,
   output logic              MEM_AWREADY,
   input  logic [DW-1:0]     MEM_WDATA,
   input  logic [DW/8-1:0]   MEM_WSTRB,
   input  logic              MEM_WLAST,
   input  logic              MEM_WVALID,
   output logic              MEM_WREADY,
   output logic [IW-1:0]     MEM_BID,
   output logic [1:0]        MEM_BRESP,
   output logic              MEM_BVALID,
   input  logic              MEM_BREADY,
   input  logic [IW-1:0]     MEM_ARID,
   input  logic [ADDR_W-1:0] MEM_ARADDR,
   input  logic [7:0]        MEM_ARLEN,
   input  logic [2:0]        MEM_ARSIZE,
   input  logic [1:0]        MEM_ARBURST,
   input  logic              MEM_ARVALID,
   output logic              MEM_ARREADY,
   output logic [IW-1:0]     MEM_RID,
   output logic [DW-1:0]     MEM_RDATA,
   output logic [1:0]        MEM_RRESP,
   output logic              MEM_RLAST,
   output logic              MEM_RVALID,
   input  logic              MEM_RREADY
);
   localparam int OFF   = $clog2(DW/8);
   localparam int SW    = DW/8;
   localparam int DEPTH = 2**AW;

   localparam logic [1:0] OKAY    = 2'd0;
   localparam logic [1:0] SLVERR  = 2'd2;
   localparam logic [1:0] DECERR  = 2'd3;
   localparam logic [1:0] B_FIXED = 2'd0;
   localparam logic [1:0] B_INCR  = 2'd1;
   localparam logic [1:0] B_WRAP  = 2'd2;

   typedef logic [ADDR_W-1:0] addr_t;

   logic [DW-1:0] ram [DEPTH];

   // Reserved burst type or a WRAP length that is not 2/4/8/16 beats
   function automatic logic bad_burst(input logic [1:0] b,
                                      input logic [7:0] len);
      logic wrap_ok;
      wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                (len == 8'd7) || (len == 8'd15);
      return (b == 2'd3) || ((b == B_WRAP) && !wrap_ok);
   endfunction

   // Illegal bursts are still walked, as INCR
   function automatic logic [1:0] eff_burst(input logic [1:0] b,
                                            input logic [7:0] len);
      return bad_burst(b, len) ? B_INCR : b;
   endfunction

   function automatic logic out_of_range(input addr_t a);
      return |a[ADDR_W-1:AW+OFF];
   endfunction

   function automatic logic [AW-1:0] word_of(input addr_t a);
      return a[AW+OFF-1:OFF];
   endfunction

   function automatic addr_t next_addr(input addr_t      a,
                                       input logic [7:0] len,
                                       input logic [2:0] size,
                                       input logic [1:0] b);
      addr_t step;
      addr_t span;
      step = addr_t'(1) << size;
      span = (addr_t'(len) + addr_t'(1)) << size;
      case (b)
         B_FIXED: return a;
         B_WRAP:  return (a & ~(span - addr_t'(1))) |
                         ((a + step) & (span - addr_t'(1)));
         default: return (a & ~(step - addr_t'(1))) + step;
      endcase
   endfunction

   // ---------------- write channel ----------------
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

   w_state_e      w_state_q, w_state_d;
   logic          awready_q, awready_d;
   logic [IW-1:0] wid_q, wid_d;
   addr_t         waddr_q, waddr_d;
   logic [7:0]    wlen_q, wlen_d;
   logic [7:0]    wbeat_q, wbeat_d;
   logic [2:0]    wsize_q, wsize_d;
   logic [1:0]    wburst_q, wburst_d;
   logic [1:0]    wresp_q, wresp_d;
   logic [1:0]    wbeat_resp;
   logic          w_we;
   logic          w_dec;
   logic          w_final;

   // Write FSM: capture AW, walk beats, keep worst response, hold B
   always_comb begin
      w_state_d  = w_state_q;
      wid_d      = wid_q;
      waddr_d    = waddr_q;
      wlen_d     = wlen_q;
      wbeat_d    = wbeat_q;
      wsize_d    = wsize_q;
      wburst_d   = wburst_q;
      wresp_d    = wresp_q;
      wbeat_resp = OKAY;
      w_we       = 1'b0;
      w_dec      = out_of_range(waddr_q);
      w_final    = (wbeat_q == wlen_q);
      unique case (w_state_q)
         W_IDLE: begin
            if (awready_q && MEM_AWVALID) begin
               wid_d     = MEM_AWID;
               waddr_d   = MEM_AWADDR;
               wlen_d    = MEM_AWLEN;
               wsize_d   = MEM_AWSIZE;
               wburst_d  = eff_burst(MEM_AWBURST, MEM_AWLEN);
               wresp_d   = bad_burst(MEM_AWBURST, MEM_AWLEN) ?
                           SLVERR : OKAY;
               wbeat_d   = 8'd0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (MEM_WVALID) begin
               w_we = !w_dec;
               if (w_dec) begin
                  wbeat_resp = DECERR;
               end else if (MEM_WLAST != w_final) begin
                  wbeat_resp = SLVERR;
               end
               if (wbeat_resp > wresp_q) begin
                  wresp_d = wbeat_resp;
               end
               waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
               wbeat_d = wbeat_q + 8'd1;
               if (w_final) begin
                  w_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (MEM_BREADY) begin
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
   end

   // Write channel state registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         wresp_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wid_q     <= wid_d;
         waddr_q   <= waddr_d;
         wlen_q    <= wlen_d;
         wbeat_q   <= wbeat_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         wresp_q   <= wresp_d;
      end
   end

   // Byte-enabled array write; contents survive reset
   always_ff @(posedge clock) begin
      if (w_we) begin
         for (int b = 0; b < SW; b++) begin
            if (MEM_WSTRB[b]) begin
               ram[word_of(waddr_q)][8*b +: 8] <= MEM_WDATA[8*b +: 8];
            end
         end
      end
   end

   assign MEM_AWREADY = awready_q;
   assign MEM_WREADY  = (w_state_q == W_DATA);
   assign MEM_BVALID  = (w_state_q == W_RESP);
   assign MEM_BID     = wid_q;
   assign MEM_BRESP   = wresp_q;

   // ---------------- read channel ----------------
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

   r_state_e      r_state_q, r_state_d;
   logic          arready_q, arready_d;
   logic [IW-1:0] rid_q, rid_d;
   addr_t         raddr_q, raddr_d;
   logic [7:0]    rlen_q, rlen_d;
   logic [7:0]    rbeat_q, rbeat_d;
   logic [2:0]    rsize_q, rsize_d;
   logic [1:0]    rburst_q, rburst_d;
   logic          rerr_q, rerr_d;
   logic [3:0]    rwait_q, rwait_d;
   logic          rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [1:0]    rresp_q, rresp_d;
   logic          rlast_q, rlast_d;
   logic          ld;
   addr_t         ld_addr;
   logic [7:0]    ld_beat;
   logic [7:0]    ld_len;
   logic          ld_err;

   // Read FSM: latency count, then load one beat per R handshake
   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      raddr_d   = raddr_q;
      rlen_d    = rlen_q;
      rbeat_d   = rbeat_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rerr_d    = rerr_q;
      rwait_d   = rwait_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      ld        = 1'b0;
      ld_addr   = raddr_q;
      ld_beat   = rbeat_q;
      ld_len    = rlen_q;
      ld_err    = rerr_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (arready_q && MEM_ARVALID) begin
               rid_d    = MEM_ARID;
               raddr_d  = MEM_ARADDR;
               rlen_d   = MEM_ARLEN;
               rsize_d  = MEM_ARSIZE;
               rburst_d = eff_burst(MEM_ARBURST, MEM_ARLEN);
               rerr_d   = bad_burst(MEM_ARBURST, MEM_ARLEN);
               rbeat_d  = 8'd0;
               if (RD_LAT == 0) begin
                  ld        = 1'b1;
                  ld_addr   = MEM_ARADDR;
                  ld_beat   = 8'd0;
                  ld_len    = MEM_ARLEN;
                  ld_err    = bad_burst(MEM_ARBURST, MEM_ARLEN);
                  r_state_d = R_DATA;
               end else begin
                  rwait_d   = 4'(RD_LAT - 1);
                  r_state_d = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            if (rwait_q == 4'd0) begin
               ld        = 1'b1;
               r_state_d = R_DATA;
            end else begin
               rwait_d = rwait_q - 4'd1;
            end
         end
         R_DATA: begin
            if (MEM_RREADY) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  r_state_d = R_IDLE;
               end else begin
                  ld      = 1'b1;
                  ld_addr = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                  ld_beat = rbeat_q + 8'd1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (ld) begin
         rvalid_d = 1'b1;
         raddr_d  = ld_addr;
         rbeat_d  = ld_beat;
         rlast_d  = (ld_beat == ld_len);
         if (out_of_range(ld_addr)) begin
            rdata_d = '0;
            rresp_d = DECERR;
         end else begin
            rdata_d = ram[word_of(ld_addr)];
            rresp_d = ld_err ? SLVERR : OKAY;
         end
      end
      arready_d = (r_state_d == R_IDLE);
   end

   // Read channel state and registered R outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rerr_q    <= 1'b0;
         rwait_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rid_q     <= rid_d;
         raddr_q   <= raddr_d;
         rlen_q    <= rlen_d;
         rbeat_q   <= rbeat_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rerr_q    <= rerr_d;
         rwait_q   <= rwait_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   assign MEM_ARREADY = arready_q;
   assign MEM_RVALID  = rvalid_q;
   assign MEM_RID     = rid_q;
   assign MEM_RDATA   = rdata_q;
   assign MEM_RRESP   = rresp_q;
   assign MEM_RLAST   = rlast_q;

endmodule

// File: tb/tb_axi4_sim_sram.sv
// Bench for axi4_sim_sram: directed steps plus random bursts
// checked against a word-array model of the memory.
module tb_axi4_sim_sram;
   localparam int RD_LAT = 2;
   localparam logic [31:0] LIMIT = 32'h0004_0000;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [3:0]   MEM_AWID = '0;
   logic [31:0]  MEM_AWADDR = '0;
   logic [7:0]   MEM_AWLEN = '0;
   logic [2:0]   MEM_AWSIZE = '0;
   logic [1:0]   MEM_AWBURST = '0;
   logic         MEM_AWVALID = 1'b0;
   logic         MEM_AWREADY;
   logic [127:0] MEM_WDATA = '0;
   logic [15:0]  MEM_WSTRB = '0;
   logic         MEM_WLAST = 1'b0;
   logic         MEM_WVALID = 1'b0;
   logic         MEM_WREADY;
   logic [3:0]   MEM_BID;
   logic [1:0]   MEM_BRESP;
   logic         MEM_BVALID;
   logic         MEM_BREADY = 1'b0;
   logic [3:0]   MEM_ARID = '0;
   logic [31:0]  MEM_ARADDR = '0;
   logic [7:0]   MEM_ARLEN = '0;
   logic [2:0]   MEM_ARSIZE = '0;
   logic [1:0]   MEM_ARBURST = '0;
   logic         MEM_ARVALID = 1'b0;
   logic         MEM_ARREADY;
   logic [3:0]   MEM_RID;
   logic [127:0] MEM_RDATA;
   logic [1:0]   MEM_RRESP;
   logic         MEM_RLAST;
   logic         MEM_RVALID;
   logic         MEM_RREADY = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [127:0] mem [16384];
   logic [127:0] wdat [16];
   logic [15:0]  wstb [16];

   axi4_sim_sram #(.DW(128), .AW(14), .IW(4), .ADDR_W(32), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .reset(reset),
      .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
      .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST),
      .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
      .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
      .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
      .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID),
      .MEM_BREADY(MEM_BREADY),
      .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
      .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST),
      .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
      .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP),
      .MEM_RLAST(MEM_RLAST), .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [159:0] obs,
                      input logic [159:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic is_bad(input logic [1:0] b, input int len);
      return (b == 2'd3) ||
             ((b == 2'd2) && !(len == 1 || len == 3 || len == 7 || len == 15));
   endfunction

   // Address of beat k, straight from the burst rules
   function automatic logic [31:0] beat_addr(input logic [31:0] a,
                                             input int len, input int size,
                                             input logic [1:0] burst,
                                             input int k);
      logic [31:0] step, w, base;
      logic [1:0]  b;
      b    = is_bad(burst, len) ? 2'd1 : burst;
      step = 32'd1 << size;
      if (b == 2'd0) return a;
      if (b == 2'd2) begin
         w    = 32'(len + 1) * step;
         base = a - (a % w);
         return base + ((a - base + 32'(k) * step) % w);
      end
      if (k == 0) return a;
      return (a - (a % step)) + 32'(k) * step;
   endfunction

   task automatic wait_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic do_write(input string tag, input logic [3:0] id,
                           input logic [31:0] addr, input int len,
                           input int size, input logic [1:0] burst,
                           input int last_at);
      logic [1:0]  eresp;
      logic [31:0] ba;
      int          n;
      eresp = is_bad(burst, len) ? 2'd2 : 2'd0;
      if (last_at != len) eresp = 2'd2;
      for (int k = 0; k <= len; k++) begin
         ba = beat_addr(addr, len, size, burst, k);
         if (ba >= LIMIT) begin
            eresp = 2'd3;
         end else begin
            for (int b = 0; b < 16; b++)
               if (wstb[k][b]) mem[ba[17:4]][8*b +: 8] = wdat[k][8*b +: 8];
         end
      end
      MEM_AWID = id; MEM_AWADDR = addr; MEM_AWLEN = 8'(len);
      MEM_AWSIZE = 3'(size); MEM_AWBURST = burst; MEM_AWVALID = 1'b1;
      n = 0;
      while (!MEM_AWREADY && n < 50) begin wait_edge(); n++; end
      chk({tag, "_aw_tmo"}, 160'(n < 50), 160'(1));
      wait_edge();
      MEM_AWVALID = 1'b0;
      for (int k = 0; k <= len; k++) begin
         MEM_WDATA = wdat[k]; MEM_WSTRB = wstb[k];
         MEM_WLAST = (k == last_at) || (last_at == len && k == len);
         MEM_WVALID = 1'b1;
         n = 0;
         while (!MEM_WREADY && n < 50) begin wait_edge(); n++; end
         chk({tag, "_w_tmo"}, 160'(n < 50), 160'(1));
         wait_edge();
      end
      MEM_WVALID = 1'b0; MEM_WLAST = 1'b0;
      MEM_BREADY = 1'b1;
      n = 0;
      while (!MEM_BVALID && n < 50) begin wait_edge(); n++; end
      chk({tag, "_b_tmo"}, 160'(n < 50), 160'(1));
      chk({tag, "_bid"}, 160'(MEM_BID), 160'(id));
      chk({tag, "_bresp"}, 160'(MEM_BRESP), 160'(eresp));
      wait_edge();
      MEM_BREADY = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [3:0] id,
                          input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst,
                          input bit toggle, input bit chk_lat);
      logic [31:0]  ba;
      logic [127:0] ed;
      logic [1:0]   er;
      int n, lat, got, cyc;
      MEM_ARID = id; MEM_ARADDR = addr; MEM_ARLEN = 8'(len);
      MEM_ARSIZE = 3'(size); MEM_ARBURST = burst; MEM_ARVALID = 1'b1;
      n = 0;
      while (!MEM_ARREADY && n < 50) begin wait_edge(); n++; end
      chk({tag, "_ar_tmo"}, 160'(n < 50), 160'(1));
      wait_edge();
      MEM_ARVALID = 1'b0;
      lat = 1;
      while (!MEM_RVALID && lat < 40) begin wait_edge(); lat++; end
      if (chk_lat) chk({tag, "_lat"}, 160'(lat), 160'(RD_LAT + 1));
      got = 0; cyc = 0;
      while (got <= len && cyc < 4 * len + 40) begin
         MEM_RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
         if (MEM_RVALID) begin
            ba = beat_addr(addr, len, size, burst, got);
            if (ba >= LIMIT) begin
               ed = '0; er = 2'd3;
            end else begin
               ed = mem[ba[17:4]]; er = is_bad(burst, len) ? 2'd2 : 2'd0;
            end
            chk($sformatf("%s_beat%0d", tag, got),
                160'({MEM_RID, MEM_RLAST, MEM_RRESP, MEM_RDATA}),
                160'({id, (got == len), er, ed}));
            if (MEM_RREADY) got++;
         end
         wait_edge();
         cyc++;
      end
      MEM_RREADY = 1'b0;
      chk({tag, "_r_tmo"}, 160'(got > len), 160'(1));
      chk({tag, "_rend"}, 160'(MEM_RVALID), 160'(0));
   endtask

   initial begin
      int len, wd, n;
      logic [1:0] b;
      // reset values
      repeat (3) wait_edge();
      chk("rst_ctl", 160'({MEM_AWREADY, MEM_ARREADY, MEM_WREADY,
                           MEM_BVALID, MEM_RVALID, MEM_RLAST}), 160'(0));
      chk("rst_dat", 160'({MEM_RID, MEM_RRESP, MEM_BID, MEM_BRESP, MEM_RDATA}),
          160'(0));
      reset = 1'b0;
      chk("rel_aw0", 160'({MEM_AWREADY, MEM_ARREADY}), 160'(0));
      wait_edge();
      chk("rel_aw1", 160'({MEM_AWREADY, MEM_ARREADY}), 160'(3));

      // preload words 0..63
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 16; k++) begin
            wdat[k] = {$urandom, $urandom, $urandom, $urandom};
            wstb[k] = 16'hFFFF;
         end
         if (c == 0) wdat[0] = 128'h0F0E0D0C0B0A09080706050403020100;
         do_write("pre", 4'(c), 32'(c * 256), 15, 4, 2'd1, 15);
      end
      do_read("rd0", 4'd5, 32'h0, 0, 4, 2'd1, 1'b0, 1'b1);

      // INCR write then stalled read-back
      for (int k = 0; k < 4; k++) begin
         wdat[k] = 128'(k); wstb[k] = 16'hFFFF;
      end
      do_write("w30", 4'd9, 32'h30, 3, 4, 2'd1, 3);
      do_read("r30", 4'd3, 32'h30, 3, 4, 2'd1, 1'b1, 1'b1);

      do_read("wrap", 4'd6, 32'h20, 3, 4, 2'd2, 1'b0, 1'b0);
      do_read("fixed", 4'd7, 32'h20, 2, 4, 2'd0, 1'b0, 1'b0);

      // partial strobe
      wdat[0] = {$urandom, $urandom, $urandom, $urandom};
      wstb[0] = 16'h0003;
      do_write("strb", 4'd1, 32'h100, 0, 4, 2'd1, 0);
      do_read("rstrb", 4'd1, 32'h100, 0, 4, 2'd1, 1'b0, 1'b0);

      // decode error
      wdat[0] = {$urandom, $urandom, $urandom, $urandom};
      wstb[0] = 16'hFFFF;
      do_write("dec", 4'd2, LIMIT, 0, 4, 2'd1, 0);
      do_read("rdec", 4'd2, LIMIT, 0, 4, 2'd1, 1'b0, 1'b0);
      do_read("r0", 4'd8, 32'h0, 0, 4, 2'd1, 1'b0, 1'b0);

      // early WLAST, reserved burst, illegal WRAP length
      for (int k = 0; k < 4; k++) begin
         wdat[k] = {$urandom, $urandom, $urandom, $urandom};
         wstb[k] = 16'hFFFF;
      end
      do_write("wlast", 4'd3, 32'h200, 3, 4, 2'd1, 1);
      do_read("rwl", 4'd3, 32'h200, 3, 4, 2'd1, 1'b0, 1'b0);
      do_write("b3", 4'd4, 32'h280, 1, 4, 2'd3, 1);
      do_read("rb3", 4'd4, 32'h280, 1, 4, 2'd3, 1'b0, 1'b0);
      do_read("wrap2", 4'd10, 32'h2C0, 2, 4, 2'd2, 1'b1, 1'b0);

      // random bursts
      for (int it = 0; it < 10; it++) begin
         b = 2'($urandom_range(0, 2));
         if (b == 2'd2) len = (2 << $urandom_range(0, 2)) - 1;
         else len = $urandom_range(0, 7);
         wd = $urandom_range(0, 63 - len);
         for (int k = 0; k <= len; k++) begin
            wdat[k] = {$urandom, $urandom, $urandom, $urandom};
            wstb[k] = 16'($urandom);
         end
         do_write("rw", 4'($urandom), 32'(wd * 16), len, 4, b, len);
         do_read("rr", 4'($urandom), 32'(wd * 16), len, 4, b,
                 1'($urandom), 1'b0);
      end

      // reset in the middle of a read burst
      MEM_ARID = 4'd1; MEM_ARADDR = 32'h30; MEM_ARLEN = 8'd3;
      MEM_ARSIZE = 3'd4; MEM_ARBURST = 2'd1; MEM_ARVALID = 1'b1;
      n = 0;
      while (!MEM_ARREADY && n < 50) begin wait_edge(); n++; end
      wait_edge();
      MEM_ARVALID = 1'b0;
      while (!MEM_RVALID && n < 100) begin wait_edge(); n++; end
      chk("mid_rv", 160'(MEM_RVALID), 160'(1));
      #2 reset = 1'b1;
      #1;
      chk("mid_rst", 160'({MEM_RVALID, MEM_ARREADY, MEM_AWREADY}), 160'(0));
      wait_edge();
      reset = 1'b0;
      chk("mid_rel0", 160'(MEM_ARREADY), 160'(0));
      wait_edge();
      chk("mid_rel1", 160'(MEM_ARREADY), 160'(1));
      do_read("keep", 4'd11, 32'h30, 3, 4, 2'd1, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
